// File: rtl/lcplc_pkg.sv
// Shared types and default widths for the LCPLC flag generator.
package lcplc_pkg;

  localparam int LCPLC_DATA_WIDTH        = 16;
  localparam int LCPLC_BLOCK_DIM_WIDTH   = 6;
  localparam int LCPLC_BAND_WIDTH        = 10;
  localparam int LCPLC_BLOCK_COUNT_WIDTH = 16;

  typedef struct packed {
    logic [LCPLC_BLOCK_COUNT_WIDTH-1:0] blocks_m1;
    logic [LCPLC_BAND_WIDTH-1:0]        bands_m1;
    logic [LCPLC_BLOCK_DIM_WIDTH-1:0]   height_m1;
    logic [LCPLC_BLOCK_DIM_WIDTH-1:0]   width_m1;
  } lcplc_geom_t;

  typedef struct packed {
    logic i;
    logic b;
    logic s;
    logic r;
  } lcplc_flags_t;

endpackage

// File: rtl/lcplc_flag_generator_wrap_counter.sv
// Up-counter that wraps to zero after reaching a runtime limit.
module wrap_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  logic [WIDTH-1:0] r_count;

  assign at_limit = (r_count == limit);
  assign count    = r_count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= at_limit ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/lcplc_flag_generator.sv
// Tags a block-ordered sample stream with nested row/slice/block/image last flags.
// state | meaning
// IDLE  | waiting for first sample of an image; cfg_* used live and captured on transfer
// RUN   | image in progress; captured geometry used, cfg_* ignored
module lcplc_flag_generator
  import lcplc_pkg::*;
#(
  parameter int DATA_WIDTH        = LCPLC_DATA_WIDTH,
  parameter int BLOCK_DIM_WIDTH   = LCPLC_BLOCK_DIM_WIDTH,
  parameter int BAND_WIDTH        = LCPLC_BAND_WIDTH,
  parameter int BLOCK_COUNT_WIDTH = LCPLC_BLOCK_COUNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         input_valid,
  output logic                         input_ready,
  input  logic [DATA_WIDTH-1:0]        input_data,
  output logic                         x_valid,
  input  logic                         x_ready,
  output logic [DATA_WIDTH-1:0]        x_data,
  output logic                         x_last_r,
  output logic                         x_last_s,
  output logic                         x_last_b,
  output logic                         x_last_i,
  input  logic [BLOCK_DIM_WIDTH-1:0]   cfg_width_m1,
  input  logic [BLOCK_DIM_WIDTH-1:0]   cfg_height_m1,
  input  logic [BAND_WIDTH-1:0]        cfg_bands_m1,
  input  logic [BLOCK_COUNT_WIDTH-1:0] cfg_blocks_m1,
  output logic                         busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]                   r_state;
  logic [BLOCK_DIM_WIDTH-1:0]   r_width_m1, r_height_m1;
  logic [BAND_WIDTH-1:0]        r_bands_m1;
  logic [BLOCK_COUNT_WIDTH-1:0] r_blocks_m1;
  logic                         r_valid, r_busy;
  logic [DATA_WIDTH-1:0]        r_data;
  lcplc_flags_t                 r_flags;

  logic [BLOCK_DIM_WIDTH-1:0]   w_width_m1, w_height_m1;
  logic [BAND_WIDTH-1:0]        w_bands_m1;
  logic [BLOCK_COUNT_WIDTH-1:0] w_blocks_m1;
  logic [BLOCK_DIM_WIDTH-1:0]   w_col, w_row;
  logic [BAND_WIDTH-1:0]        w_band;
  logic [BLOCK_COUNT_WIDTH-1:0] w_blk;
  logic                         w_col_at, w_row_at, w_band_at, w_blk_at;
  logic                         w_en_row, w_en_band, w_en_blk;
  logic                         w_xfer, w_idle;
  lcplc_flags_t                 w_flags;
  logic                         w_unused_counts;

  // The first sample of an image is tagged against the live cfg it captures.
  assign w_idle      = (r_state == S_IDLE);
  assign w_width_m1  = w_idle ? cfg_width_m1  : r_width_m1;
  assign w_height_m1 = w_idle ? cfg_height_m1 : r_height_m1;
  assign w_bands_m1  = w_idle ? cfg_bands_m1  : r_bands_m1;
  assign w_blocks_m1 = w_idle ? cfg_blocks_m1 : r_blocks_m1;

  assign input_ready = !r_valid || x_ready;
  assign w_xfer      = input_valid && input_ready;

  assign w_en_row  = w_xfer    && w_col_at;
  assign w_en_band = w_en_row  && w_row_at;
  assign w_en_blk  = w_en_band && w_band_at;

  assign w_flags.r = w_col_at;
  assign w_flags.s = w_flags.r && w_row_at;
  assign w_flags.b = w_flags.s && w_band_at;
  assign w_flags.i = w_flags.b && w_blk_at;

  assign w_unused_counts = ^{w_col, w_row, w_band, w_blk};

  wrap_counter #(.WIDTH(BLOCK_DIM_WIDTH)) u_col (
    .clk(clk), .rst(rst), .clear(1'b0), .enable(w_xfer),
    .limit(w_width_m1), .count(w_col), .at_limit(w_col_at)
  );

  wrap_counter #(.WIDTH(BLOCK_DIM_WIDTH)) u_row (
    .clk(clk), .rst(rst), .clear(1'b0), .enable(w_en_row),
    .limit(w_height_m1), .count(w_row), .at_limit(w_row_at)
  );

  wrap_counter #(.WIDTH(BAND_WIDTH)) u_band (
    .clk(clk), .rst(rst), .clear(1'b0), .enable(w_en_band),
    .limit(w_bands_m1), .count(w_band), .at_limit(w_band_at)
  );

  wrap_counter #(.WIDTH(BLOCK_COUNT_WIDTH)) u_blk (
    .clk(clk), .rst(rst), .clear(1'b0), .enable(w_en_blk),
    .limit(w_blocks_m1), .count(w_blk), .at_limit(w_blk_at)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_width_m1  <= '0;
      r_height_m1 <= '0;
      r_bands_m1  <= '0;
      r_blocks_m1 <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_flags     <= '0;
      r_busy      <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_valid <= 1'b1;
        r_data  <= input_data;
        r_flags <= w_flags;
        r_state <= w_flags.i ? S_IDLE : S_RUN;
        if (w_idle) begin
          r_width_m1  <= cfg_width_m1;
          r_height_m1 <= cfg_height_m1;
          r_bands_m1  <= cfg_bands_m1;
          r_blocks_m1 <= cfg_blocks_m1;
        end
      end else if (x_ready) begin
        r_valid <= 1'b0;
      end
      // Busy stays up through the cycle the final sample sits in the output register.
      r_busy <= w_xfer || (r_state == S_RUN);
    end
  end

  assign x_valid  = r_valid;
  assign x_data   = r_data;
  assign x_last_r = r_flags.r;
  assign x_last_s = r_flags.s;
  assign x_last_b = r_flags.b;
  assign x_last_i = r_flags.i;
  assign busy     = r_busy;

endmodule

// File: tb/tb_lcplc_flag_generator.sv
// Directed bench for lcplc_flag_generator with an index-based flag scoreboard.
module tb_lcplc_flag_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        input_valid = 1'b0;
  logic        input_ready;
  logic [15:0] input_data = '0;
  logic        x_valid;
  logic        x_ready = 1'b1;
  logic [15:0] x_data;
  logic        x_last_r, x_last_s, x_last_b, x_last_i;
  logic [5:0]  cfg_width_m1  = 6'd1;
  logic [5:0]  cfg_height_m1 = 6'd1;
  logic [9:0]  cfg_bands_m1  = 10'd2;
  logic [15:0] cfg_blocks_m1 = 16'd1;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] d;
    logic        r;
    logic        s;
    logic        b;
    logic        i;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   m_idx  = 0;
  bit   m_idle = 1'b1;
  int   m_w, m_h, m_b, m_n;

  always #5 clk = ~clk;

  lcplc_flag_generator dut (
    .clk(clk), .rst(rst),
    .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .x_last_r(x_last_r), .x_last_s(x_last_s), .x_last_b(x_last_b), .x_last_i(x_last_i),
    .cfg_width_m1(cfg_width_m1), .cfg_height_m1(cfg_height_m1),
    .cfg_bands_m1(cfg_bands_m1), .cfg_blocks_m1(cfg_blocks_m1),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags from position within the image, using geometry latched at image start.
  task automatic push_expected(input logic [15:0] d);
    int wh, whb, tot;
    exp_t e;
    if (m_idle) begin
      m_w = int'(cfg_width_m1) + 1;
      m_h = int'(cfg_height_m1) + 1;
      m_b = int'(cfg_bands_m1) + 1;
      m_n = int'(cfg_blocks_m1) + 1;
      m_idle = 1'b0;
    end
    wh  = m_w * m_h;
    whb = wh * m_b;
    tot = whb * m_n;
    e.d = d;
    e.r = ((m_idx % m_w) == m_w - 1);
    e.s = ((m_idx % wh) == wh - 1);
    e.b = ((m_idx % whb) == whb - 1);
    e.i = (m_idx == tot - 1);
    q.push_back(e);
    m_idx++;
    if (e.i) begin
      m_idx  = 0;
      m_idle = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_idx  = 0;
      m_idle = 1'b1;
    end else begin
      if (x_valid && x_ready) begin
        chk("output_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          chk("sample_flags", 32'({x_data, x_last_r, x_last_s, x_last_b, x_last_i}), 32'(mon_e));
        end
      end
      if (input_valid && input_ready) push_expected(input_data);
    end
  end

  task automatic send(input logic [15:0] d);
    input_valid = 1'b1;
    input_data  = d;
    @(negedge clk);
    chk("input_ready", 32'(input_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_x_valid", 32'(x_valid), 32'd0);
    chk("rst_x_data", 32'(x_data), 32'd0);
    chk("rst_flags", 32'({x_last_r, x_last_s, x_last_b, x_last_i}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_input_ready", 32'(input_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Image 1: W=2 H=2 B=3 N=2; width cfg changes mid-image and must be ignored
    for (int k = 0; k <= 6; k++) begin
      send(16'(k));
      if (k == 4) cfg_width_m1 = 6'd3;
    end

    x_ready     = 1'b0;
    input_valid = 1'b1;
    input_data  = 16'd7;
    repeat (5) begin
      @(negedge clk);
      chk("hold_x_valid", 32'(x_valid), 32'd1);
      chk("hold_x_data", 32'(x_data), 32'd6);
      chk("hold_flags", 32'({x_last_r, x_last_s, x_last_b, x_last_i}), 32'd0);
      chk("hold_input_ready", 32'(input_ready), 32'd0);
    end
    @(posedge clk); #1;
    x_ready = 1'b1;

    for (int k = 7; k <= 23; k++) send(16'(k));
    input_valid = 1'b0;
    @(negedge clk);
    chk("last_x_data", 32'(x_data), 32'd23);
    chk("last_flags", 32'({x_last_r, x_last_s, x_last_b, x_last_i}), 32'hF);
    chk("last_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_image_busy", 32'(busy), 32'd0);
    chk("post_image_x_valid", 32'(x_valid), 32'd0);
    @(posedge clk); #1;

    // Image 2 picks up W=4; reset after its tenth sample
    for (int k = 24; k <= 33; k++) send(16'(k));
    input_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_x_valid", 32'(x_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_x_data", 32'(x_data), 32'd0);
    @(posedge clk); #1;

    // W=1 H=2 B=1 N=1: two images back to back
    cfg_width_m1  = 6'd0;
    cfg_height_m1 = 6'd1;
    cfg_bands_m1  = 10'd0;
    cfg_blocks_m1 = 16'd0;
    for (int k = 100; k <= 103; k++) send(16'(k));

    // Degenerate geometry with gaps: every sample is a complete image
    cfg_height_m1 = 6'd0;
    for (int k = 5; k <= 7; k++) begin
      send(16'(k));
      input_valid = 1'b0;
      @(negedge clk);
      chk("degen_busy_high", 32'(busy), 32'd1);
      chk("degen_flags", 32'({x_last_r, x_last_s, x_last_b, x_last_i}), 32'hF);
      @(posedge clk); #1;
      @(negedge clk);
      chk("degen_busy_low", 32'(busy), 32'd0);
      chk("degen_x_valid_low", 32'(x_valid), 32'd0);
      @(posedge clk); #1;
    end

    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
